// File: rtl/reg_scoreboard_dec.sv
// Register-file write-enable decoder with a pending-write (busy bit) scoreboard.
// Produces RAW stall and WAW issue-ready for decode, and a registered one-hot write enable.
module reg_scoreboard_dec #(
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 2**ADDR_W,
    parameter int ZERO_REG = 31
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_rd,
    output logic                iss_ready,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_rd,
    input  logic [ADDR_W-1:0]   rd_a1,
    input  logic [ADDR_W-1:0]   rd_a2,
    output logic                stall,
    output logic [NUM_REGS-1:0] wb_en,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                err_spurious
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    function automatic logic [NUM_REGS-1:0] decode_onehot(
        input logic [ADDR_W-1:0] addr,
        input logic              en
    );
        logic [NUM_REGS-1:0] vec_s;
        if (en) begin
            vec_s = NUM_REGS'(1'b1) << addr;
        end else begin
            vec_s = '0;
        end
        return vec_s;
    endfunction

    // A source is hazardous only if its producer is not writing back this very cycle.
    function automatic logic raw_hit(
        input logic [NUM_REGS-1:0] busy,
        input logic [ADDR_W-1:0]   src,
        input logic                clr,
        input logic [ADDR_W-1:0]   clr_addr
    );
        return (src != ZERO_ADDR) && busy[src] && !(clr && (clr_addr == src));
    endfunction

    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_nxt_s;
    logic [NUM_REGS-1:0] wb_en_r;
    logic                err_r;
    logic                wb_clr_s;
    logic                iss_ready_s;
    logic                iss_fire_s;
    logic                stall_s;

    // Hazard detection and issue handshake.
    always_comb begin
        wb_clr_s    = wb_valid && (wb_rd != ZERO_ADDR);
        iss_ready_s = !flush && ((iss_rd == ZERO_ADDR) || !busy_r[iss_rd] ||
                                 (wb_clr_s && (wb_rd == iss_rd)));
        iss_fire_s  = iss_valid && iss_ready_s;
        stall_s     = raw_hit(busy_r, rd_a1, wb_clr_s, wb_rd) ||
                      raw_hit(busy_r, rd_a2, wb_clr_s, wb_rd);
    end

    // Next scoreboard state; set is applied after clear so a new producer wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (flush) begin
            busy_nxt_s = '0;
        end else begin
            if (wb_clr_s) begin
                busy_nxt_s[wb_rd] = 1'b0;
            end else begin
                busy_nxt_s = busy_r;
            end
            if (iss_fire_s && (iss_rd != ZERO_ADDR)) begin
                busy_nxt_s[iss_rd] = 1'b1;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
        end
    end

    // Scoreboard, write-enable and sticky error registers; write-backs commit even under flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r  <= '0;
            wb_en_r <= '0;
            err_r   <= 1'b0;
        end else begin
            busy_r  <= busy_nxt_s;
            wb_en_r <= decode_onehot(wb_rd, wb_clr_s);
            if (wb_clr_s && !busy_r[wb_rd] && !flush) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign iss_ready    = iss_ready_s;
    assign stall        = stall_s;
    assign wb_en        = wb_en_r;
    assign busy_vec     = busy_r;
    assign err_spurious = err_r;

endmodule

// File: doc/reg_scoreboard_dec.md
Name: reg_scoreboard_dec

Overview:
- Parametrised register-file write-enable decoder with a pending-write scoreboard.
- Decodes a registered write-back address into a one-hot register write-enable vector, one cycle after write-back.
- Keeps one busy bit per architectural register. Issue sets the bit and write-back clears it.
- Gives the decode stage a RAW stall signal and a WAW issue-ready signal. Sits between decode/issue and the register file.

Parameters:
- ADDR_W, 5, register address width.
- NUM_REGS, 2**ADDR_W, number of architectural registers. Derived; do not override.
- ZERO_REG, 31, hardwired-zero register address: never busy, never written.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all busy bits (pipeline squash).
- iss_valid  input  1  an instruction with a destination register is issuing.
- iss_rd  input  ADDR_W  destination register of the issuing instruction.
- iss_ready  output  1  issue may proceed; no WAW conflict on iss_rd.
- wb_valid  input  1  a write-back is occurring this cycle.
- wb_rd  input  ADDR_W  write-back destination register.
- rd_a1  input  ADDR_W  source register 1 of the instruction in decode.
- rd_a2  input  ADDR_W  source register 2 of the instruction in decode.
- stall  output  1  RAW hazard on rd_a1 or rd_a2.
- wb_en  output  NUM_REGS  registered one-hot register-file write enable; bit i corresponds to address i.
- busy_vec  output  NUM_REGS  current scoreboard state.
- err_spurious  output  1  sticky: a write-back hit a non-busy, non-zero register.

Behaviour:
- Reset (rst_n=0, asynchronous, effective immediately, including mid-operation): busy_vec=0, wb_en=0, err_spurious=0. Combinational outputs follow from the cleared state.
- Define wb_clr = wb_valid && wb_rd!=ZERO_REG.
- iss_ready is combinational: !flush && (iss_rd==ZERO_REG || !busy[iss_rd] || (wb_clr && wb_rd==iss_rd)).
- An issue fires when iss_valid && iss_ready.
- Busy-bit update at each clock edge, priority flush > issue set > wb clear:
  - flush=1: all bits become 0 and any issue in that cycle is dropped.
  - Otherwise, an issue to r != ZERO_REG sets busy[r].
  - Otherwise, wb_clr clears busy[wb_rd].
  - Issue and write-back to the same register in the same cycle: bit ends at 1, because the new producer owns it.
  - Issue and write-back to different registers: both updates apply.
- stall is combinational. It is the OR over src in {rd_a1, rd_a2} of: src!=ZERO_REG && busy[src] && !(wb_clr && wb_rd==src).
  - This is same-cycle write-back bypass: the register file writes in the first half of the cycle.
  - stall does not depend on iss_valid.
- wb_en latency is exactly 1 cycle.
  - Next wb_en = one-hot(wb_rd) if wb_clr, else all zeros.
  - At most one bit is set; $onehot0(wb_en) holds every cycle.
  - Generate it from a parametrised decoder (no hand-enumerated gates).
- Write-back during flush still produces wb_en, because the write itself is architecturally committed.
- err_spurious is set when wb_clr && !busy[wb_rd] && !flush. It stays set until reset. The write enable is still generated.
- ZERO_REG: issue never sets its bit, reads never stall, and write-back produces no enable and no error.
- All address values are in range by construction; there is no out-of-range handling.

Test Plan:
- Reset release with all inputs 0 -> busy_vec=0, wb_en=0, stall=0, iss_ready=1, err_spurious=0. Assert rst_n=0 mid-run with busy_vec=0x0000_00F0 -> busy_vec=0 within the same cycle, before the next edge.
- Issue rd=5, next cycle rd_a1=5 -> stall=1. Later wb_valid, wb_rd=5, rd_a1=5 -> stall=0 in the same cycle. Next cycle wb_en=0x0000_0020 and busy[5]=0.
- WAW: busy[7]=1, iss_rd=7 -> iss_ready=0. Same cycle plus wb_rd=7 -> iss_ready=1. After the edge busy[7]=1 and wb_en=0x0000_0080.
- ZERO_REG: issue rd=31, wb_rd=31, rd_a2=31 -> busy_vec unchanged, wb_en=0, stall=0, err_spurious=0.
- Flush: busy_vec=0x0000_0F00, flush=1 with issue rd=2 and wb_rd=9 -> busy_vec=0 after the edge, iss_ready=0 during flush, next-cycle wb_en=0x0000_0200.
- Spurious write-back: wb_rd=12 with busy[12]=0 -> wb_en=0x0000_1000 next cycle. err_spurious=1 and remains 1 through 100 further idle cycles.
